iic_slave: RTL

- I2C responder: the target-side counterpart of the team's IIC_module initiator.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs written bytes, and serves read bytes from a user interface.
- Open-drain SDA: drives only 0 or z. SCL is input only; no clock stretching.
- Sits between board I2C pins and user logic (register file, sensor emulation, loopback against IIC_module).

---
 rtl/iic_slave.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/iic_slave.sv
// iic_slave: I2C target (responder) that oversamples SCL/SDA on i_clk.
// Detects START/STOP, matches a 7-bit address, ACKs every written byte and
// serves read bytes from the user side. SDA is open drain (0 or z); SCL is
// never driven and the block never stretches the clock.
//
// Ports:
//   i_clk        system clock, at least 20x the SCL frequency
//   i_rst        synchronous active-low reset
//   i_SCL        bus clock pin (input only)
//   o_SDA        bus data pin, driven 1'b0 or 1'bz
//   i_R_byte     byte to return on reads, captured when o_R_load=1
//   o_R_load     1-cycle pulse: i_R_byte captured on this edge
//   o_W_byte     last byte written by the master
//   o_W_valid    1-cycle pulse: o_W_byte updated
//   o_RW         R/W bit of the current addressed transfer (1=read)
//   o_busy       high from address-match ACK until STOP or repeated START
//   o_start      1-cycle pulse on START / repeated START
//   o_stop       1-cycle pulse on STOP
//   o_nack       1-cycle pulse: master NACKed a read byte
//   o_dbg_state  current FSM state (debug visibility)
//
// User-side handshake: there is no back-pressure. o_W_valid qualifies
// o_W_byte for exactly one cycle and the value then holds until the next
// completed write byte. o_R_load marks the edge on which i_R_byte was
// sampled; the user must hold the next byte on i_R_byte before the following
// o_R_load.
module iic_slave #(
  parameter logic [6:0] P_ADDRESS = 7'h3C
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_SCL,
  inout  wire        o_SDA,
  input  logic [7:0] i_R_byte,
  output logic       o_R_load,
  output logic [7:0] o_W_byte,
  output logic       o_W_valid,
  output logic       o_RW,
  output logic       o_busy,
  output logic       o_start,
  output logic       o_stop,
  output logic       o_nack,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_WRITE     = 3'd3,
    S_WRITE_ACK = 3'd4,
    S_READ      = 3'd5,
    S_READ_ACK  = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // [0],[1] = synchroniser stages, [2] = history used for edge detection
  logic [2:0] r_scl_sync;
  logic [2:0] r_sda_sync;
  logic       r_fall_d;
  logic [7:0] r_shift;
  logic [3:0] r_bit_cnt;
  logic       r_sda_low;
  logic       r_rw;
  logic       r_busy;
  logic [7:0] r_w_byte;
  logic       r_w_valid;
  logic       r_r_load;
  logic       r_start;
  logic       r_stop;
  logic       r_nack;

  logic       w_scl_rise;
  logic       w_start_det;
  logic       w_stop_det;
  logic       w_sda_bit;
  logic       w_addr_match;

  logic [7:0] w_shift_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_sda_low_nxt;
  logic       w_rw_nxt;
  logic       w_busy_nxt;
  logic [7:0] w_w_byte_nxt;
  logic       w_w_valid_nxt;
  logic       w_r_load_nxt;
  logic       w_start_nxt;
  logic       w_stop_nxt;
  logic       w_nack_nxt;

  assign w_scl_rise   = r_scl_sync[1] & ~r_scl_sync[2];
  assign w_sda_bit    = r_sda_sync[1];
  assign w_start_det  = r_scl_sync[1] & ~r_sda_sync[1] &  r_sda_sync[2];
  assign w_stop_det   = r_scl_sync[1] &  r_sda_sync[1] & ~r_sda_sync[2];
  assign w_addr_match = (r_shift[7:1] == P_ADDRESS);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic. Fall-driven moves use r_fall_d (one cycle after the
  // detected SCL fall) so every SDA change lands well inside SCL low.
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop_det) begin
      w_state_nxt = S_IDLE;
    end else if (w_start_det) begin
      w_state_nxt = S_ADDR;
    end else begin
      case (r_state)
        S_ADDR:      if (r_fall_d && r_bit_cnt == 4'd8)
                       w_state_nxt = w_addr_match ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK:  if (r_fall_d) w_state_nxt = r_rw ? S_READ : S_WRITE;
        S_WRITE:     if (r_fall_d && r_bit_cnt == 4'd8) w_state_nxt = S_WRITE_ACK;
        S_WRITE_ACK: if (r_fall_d) w_state_nxt = S_WRITE;
        S_READ:      if (r_fall_d && r_bit_cnt == 4'd8) w_state_nxt = S_READ_ACK;
        S_READ_ACK:  begin
          if (w_scl_rise && w_sda_bit) w_state_nxt = S_WAIT_STOP;
          else if (r_fall_d)           w_state_nxt = S_READ;
        end
        default: ;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_bit_cnt;
    w_sda_low_nxt = r_sda_low;
    w_rw_nxt      = r_rw;
    w_busy_nxt    = r_busy;
    w_w_byte_nxt  = r_w_byte;
    w_w_valid_nxt = 1'b0;
    w_r_load_nxt  = 1'b0;
    w_start_nxt   = 1'b0;
    w_stop_nxt    = 1'b0;
    w_nack_nxt    = 1'b0;
    if (w_stop_det) begin
      w_stop_nxt    = 1'b1;
      w_sda_low_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
    end else if (w_start_det) begin
      w_start_nxt   = 1'b1;
      w_cnt_nxt     = 4'd0;
      w_sda_low_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_WRITE: begin
          if (w_scl_rise && r_bit_cnt < 4'd8) begin
            w_shift_nxt = {r_shift[6:0], w_sda_bit};
            w_cnt_nxt   = r_bit_cnt + 4'd1;
            if (r_state == S_WRITE && r_bit_cnt == 4'd7) begin
              w_w_byte_nxt  = {r_shift[6:0], w_sda_bit};
              w_w_valid_nxt = 1'b1;
            end
          end
          if (r_fall_d && r_bit_cnt == 4'd8) begin
            if (r_state == S_WRITE) begin
              w_sda_low_nxt = 1'b1;
            end else if (w_addr_match) begin
              w_sda_low_nxt = 1'b1;
              w_rw_nxt      = r_shift[0];
              w_busy_nxt    = 1'b1;
            end
          end
        end
        S_ADDR_ACK: if (r_fall_d) begin
          w_cnt_nxt     = 4'd0;
          w_sda_low_nxt = 1'b0;
          if (r_rw) begin
            // First read byte goes out straight after the address ACK
            w_r_load_nxt  = 1'b1;
            w_shift_nxt   = i_R_byte;
            w_sda_low_nxt = ~i_R_byte[7];
            w_cnt_nxt     = 4'd1;
          end
        end
        S_WRITE_ACK: if (r_fall_d) begin
          w_sda_low_nxt = 1'b0;
          w_cnt_nxt     = 4'd0;
        end
        S_READ: if (r_fall_d) begin
          // r_bit_cnt counts bits already placed on the bus
          if (r_bit_cnt == 4'd8) begin
            w_sda_low_nxt = 1'b0;
          end else begin
            w_shift_nxt   = {r_shift[6:0], 1'b0};
            w_sda_low_nxt = ~r_shift[6];
            w_cnt_nxt     = r_bit_cnt + 4'd1;
          end
        end
        S_READ_ACK: begin
          if (w_scl_rise && w_sda_bit) begin
            w_nack_nxt = 1'b1;
          end else if (r_fall_d) begin
            w_r_load_nxt  = 1'b1;
            w_shift_nxt   = i_R_byte;
            w_sda_low_nxt = ~i_R_byte[7];
            w_cnt_nxt     = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Synchronisers and datapath registers. Synchronisers reset to the idle
  // bus level so leaving reset never looks like an edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_scl_sync <= 3'b111;
      r_sda_sync <= 3'b111;
      r_fall_d   <= 1'b0;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 4'd0;
      r_sda_low  <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_w_byte   <= 8'h00;
      r_w_valid  <= 1'b0;
      r_r_load   <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_nack     <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[1:0], i_SCL};
      r_sda_sync <= {r_sda_sync[1:0], o_SDA};
      r_fall_d   <= ~r_scl_sync[1] & r_scl_sync[2];
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_cnt_nxt;
      r_sda_low  <= w_sda_low_nxt;
      r_rw       <= w_rw_nxt;
      r_busy     <= w_busy_nxt;
      r_w_byte   <= w_w_byte_nxt;
      r_w_valid  <= w_w_valid_nxt;
      r_r_load   <= w_r_load_nxt;
      r_start    <= w_start_nxt;
      r_stop     <= w_stop_nxt;
      r_nack     <= w_nack_nxt;
    end
  end

  assign o_SDA       = r_sda_low ? 1'b0 : 1'bz;
  assign o_R_load    = r_r_load;
  assign o_W_byte    = r_w_byte;
  assign o_W_valid   = r_w_valid;
  assign o_RW        = r_rw;
  assign o_busy      = r_busy;
  assign o_start     = r_start;
  assign o_stop      = r_stop;
  assign o_nack      = r_nack;
  assign o_dbg_state = r_state;

endmodule
